vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 40, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 128, meaning hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 88, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 600, meaning visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 1, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 4, meaning vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 23, meaning vertical back porch in lines.
REQ-009 SHALL have parameter HS_POL, default 0, meaning hsync asserted level.
REQ-010 SHALL have parameter VS_POL, default 0, meaning vsync asserted level.
REQ-011 SHALL have parameter CW, default 11, meaning width of the pix_x/pix_y counters.
REQ-012 SHALL have port clk25m, input, 1 bit, the single clock.
REQ-013 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-014 SHALL have port en, input, 1 bit, pixel-tick enable (tie high at pixel rate).
REQ-015 SHALL have port hsync, output, 1 bit, horizontal sync.
REQ-016 SHALL have port vsync, output, 1 bit, vertical sync.
REQ-017 SHALL have port de, output, 1 bit, high when the presented pixel is visible.
REQ-018 SHALL have port pix_x, output, CW bits, horizontal position presented.
REQ-019 SHALL have port pix_y, output, CW bits, vertical position presented.
REQ-020 SHALL have port line_start, output, 1 bit, one-clock pulse when pix_x==0 is presented.
REQ-021 SHALL have port frame_start, output, 1 bit, one-clock pulse when (0,0) is presented.
REQ-022 SHALL have port vblank, output, 1 bit, high while pix_y >= V_ACTIVE.

Function
REQ-023 SHALL keep internal counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is formed likewise.
REQ-024 SHALL advance h by one on each clock with en=1 and hold h, v and every level output when en=0.
REQ-025 SHALL wrap h from H_TOTAL-1 to 0 and increment v on that same tick; v wraps from V_TOTAL-1 to 0 on the tick where both counters wrap.
REQ-026 SHALL register all outputs: on an en tick, outputs present the pre-increment (h,v), giving one clock of latency from counter to pins.
REQ-027 SHALL assert de for h<H_ACTIVE and v<V_ACTIVE, strict less-than, so exactly H_ACTIVE*V_ACTIVE pixels are visible per frame.
REQ-028 SHALL drive hsync=HS_POL for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-029 SHALL drive vsync=VS_POL for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line, else ~VS_POL.
REQ-030 SHALL drive pix_x=h and pix_y=v for every presented position, including blanking.
REQ-031 SHALL hold line_start and frame_start high for exactly one clock, even if en drops on the next clock.
REQ-032 SHALL fail elaboration if 2**CW < H_TOTAL or 2**CW < V_TOTAL, or if any timing parameter is 0.

Reset
REQ-033 SHALL, on a clock with rst_n=0, set h=0 and v=0 regardless of en, including mid-frame.
REQ-034 SHALL, on that reset clock, set hsync=~HS_POL, vsync=~VS_POL, de=0, pix_x=0, pix_y=0, line_start=0, frame_start=0 and vblank=0.
REQ-035 SHALL, on the first en tick after reset release, present (0,0) with de=1, line_start=1 and frame_start=1.

Structure
REQ-036 SHALL take its mode constants from shared package vga_timing_pkg, which holds 640x480@60 and 800x600@60 parameter sets and the H_TOTAL/V_TOTAL helper functions.
REQ-037 SHALL build each axis from sub-module vga_axis_counter (params ACTIVE, FP, SYNC, BP, POL, CW), instantiated once per axis; the vertical instance is enabled by the horizontal wrap.

Verification
REQ-038 SHALL check that with H=4/1/2/1 and V=3/1/1/1, en=1 and pols 0, hsync is low exactly while pix_x is 5 and 6 and de is high on 12 clocks per 48-clock frame.
REQ-039 SHALL check that with the REQ-038 parameters, frame_start pulses every 48 clocks, line_start every 8 clocks, and vsync is low for 8 clocks while pix_y=4.
REQ-040 SHALL check that with en toggling 1,0,1,0, outputs change only after en=1 clocks and pulses last one clock.
REQ-041 SHALL check that rst_n=0 at pix_x=3, pix_y=2 yields the REQ-034 values, and the next en tick yields frame_start=1 with pix_x=0.
REQ-042 SHALL check that with the defaults, a frame is 1056*628 en ticks, hsync is low at pix_x 840..967, and de is low at pix_x=800.
REQ-043 SHALL check that HS_POL=1 and VS_POL=1 invert only the sync levels, with all other outputs unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and frame-size helpers.
// Each mode is stored as active/front-porch/sync/back-porch counts per axis.
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } axis_region_e;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the registered video timing outputs; the generator side drives
// (master) and a display/sink side observes (slave).
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          line_start;
    logic          frame_start;
    logic          vblank;

    modport master (
        output hsync, vsync, de, pix_x, pix_y, line_start, frame_start, vblank
    );

    modport slave (
        input hsync, vsync, de, pix_x, pix_y, line_start, frame_start, vblank
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync region decode.
// Decode outputs describe the current (pre-increment) count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 128,
    parameter int BP     = 88,
    parameter bit POL    = 1'b0,
    parameter int CW     = 11
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tick_i,
    output logic [CW-1:0] cnt_o,
    output logic          active_o,
    output logic          sync_o
);

    localparam int TOTAL = h_total(ACTIVE, FP, SYNC, BP);

    generate
        if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 || (2 ** CW) < TOTAL) begin : g_bad_params
            $error("vga_axis_counter: zero timing field or CW too narrow for axis total");
        end
    endgenerate

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    axis_region_e  region_s;

    // Position register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next position: advance on tick, wrap after the last position
    always_comb begin
        cnt_d = cnt_q;
        if (tick_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Region classification of the current position
    always_comb begin
        region_s = REG_ACTIVE;
        if (cnt_q < ACT_END) begin
            region_s = REG_ACTIVE;
        end else if (cnt_q < SYNC_BEG) begin
            region_s = REG_FP;
        end else if (cnt_q < SYNC_END) begin
            region_s = REG_SYNC;
        end else begin
            region_s = REG_BP;
        end
    end

    // Region to output levels
    always_comb begin
        active_o = 1'b0;
        sync_o   = ~POL;
        case (region_s)
            REG_ACTIVE: active_o = 1'b1;
            REG_SYNC:   sync_o   = POL;
            REG_FP:     active_o = 1'b0;
            REG_BP:     active_o = 1'b0;
            default: begin
                active_o = 1'b0;
                sync_o   = ~POL;
            end
        endcase
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters feeding a
// registered output stage that presents the pre-increment position.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA800_H_ACTIVE,
    parameter int H_FP     = SVGA800_H_FP,
    parameter int H_SYNC   = SVGA800_H_SYNC,
    parameter int H_BP     = SVGA800_H_BP,
    parameter int V_ACTIVE = SVGA800_V_ACTIVE,
    parameter int V_FP     = SVGA800_V_FP,
    parameter int V_SYNC   = SVGA800_V_SYNC,
    parameter int V_BP     = SVGA800_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          clk25m,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank
);

    localparam int            H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);

    logic [CW-1:0] h_cnt_s;
    logic [CW-1:0] v_cnt_s;
    logic          h_active_s, v_active_s;
    logic          h_sync_s, v_sync_s;
    logic          v_tick_s;

    // The vertical axis steps only on the tick that wraps the horizontal one
    assign v_tick_s = en & (h_cnt_s == H_LAST);

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
    ) u_h_axis (
        .clk_i   (clk25m),
        .rst_ni  (rst_n),
        .tick_i  (en),
        .cnt_o   (h_cnt_s),
        .active_o(h_active_s),
        .sync_o  (h_sync_s)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
    ) u_v_axis (
        .clk_i   (clk25m),
        .rst_ni  (rst_n),
        .tick_i  (v_tick_s),
        .cnt_o   (v_cnt_s),
        .active_o(v_active_s),
        .sync_o  (v_sync_s)
    );

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          vblank_q, vblank_d;

    // Output stage next-state: capture current position on a tick; pulses drop otherwise
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        vblank_d      = vblank_q;
        if (en) begin
            hsync_d       = h_sync_s;
            vsync_d       = v_sync_s;
            de_d          = h_active_s & v_active_s;
            pix_x_d       = h_cnt_s;
            pix_y_d       = v_cnt_s;
            line_start_d  = (h_cnt_s == '0);
            frame_start_d = (h_cnt_s == '0) && (v_cnt_s == '0);
            vblank_d      = ~v_active_s;
        end else begin
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small 8x6 mode in both sync polarities and the
// default 800x600 mode share one stimulus stream, checked against a tick-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [10:0] pix_x;
        logic [10:0] pix_y;
        logic        ls;
        logic        fs;
        logic        vblank;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_gen_if #(.CW(11)) vif0 ();
    vga_timing_gen_if #(.CW(11)) vif1 ();
    vga_timing_gen_if #(.CW(11)) vif2 ();

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
    ) dut_s0 (
        .clk25m(clk), .rst_n(rst_n), .en(en),
        .hsync(vif0.hsync), .vsync(vif0.vsync), .de(vif0.de),
        .pix_x(vif0.pix_x), .pix_y(vif0.pix_y),
        .line_start(vif0.line_start), .frame_start(vif0.frame_start), .vblank(vif0.vblank)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
    ) dut_s1 (
        .clk25m(clk), .rst_n(rst_n), .en(en),
        .hsync(vif1.hsync), .vsync(vif1.vsync), .de(vif1.de),
        .pix_x(vif1.pix_x), .pix_y(vif1.pix_y),
        .line_start(vif1.line_start), .frame_start(vif1.frame_start), .vblank(vif1.vblank)
    );

    vga_timing_gen dut_def (
        .clk25m(clk), .rst_n(rst_n), .en(en),
        .hsync(vif2.hsync), .vsync(vif2.vsync), .de(vif2.de),
        .pix_x(vif2.pix_x), .pix_y(vif2.pix_y),
        .line_start(vif2.line_start), .frame_start(vif2.frame_start), .vblank(vif2.vblank)
    );

    always #5 clk = ~clk;

    out_t act0, act1, act2;
    assign act0 = {vif0.hsync, vif0.vsync, vif0.de, vif0.pix_x, vif0.pix_y, vif0.line_start, vif0.frame_start, vif0.vblank};
    assign act1 = {vif1.hsync, vif1.vsync, vif1.de, vif1.pix_x, vif1.pix_y, vif1.line_start, vif1.frame_start, vif1.vblank};
    assign act2 = {vif2.hsync, vif2.vsync, vif2.de, vif2.pix_x, vif2.pix_y, vif2.line_start, vif2.frame_start, vif2.vblank};

    // Reference: the n-th presented pixel of a frame stream sits at (n mod HT, (n / HT) mod VT)
    function automatic out_t model_at(input int ha, input int hf, input int hs, input int hb,
                                      input int va, input int vf, input int vs, input int vb,
                                      input bit hp, input bit vp, input int n);
        out_t o;
        int ht, vt, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        o.hsync  = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        o.vsync  = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        o.de     = (h < ha) && (v < va);
        o.pix_x  = 11'(h);
        o.pix_y  = 11'(v);
        o.ls     = (h == 0);
        o.fs     = (h == 0) && (v == 0);
        o.vblank = (v >= va);
        return o;
    endfunction

    function automatic out_t reset_val(input bit hp, input bit vp);
        out_t o;
        o        = '0;
        o.hsync  = !hp;
        o.vsync  = !vp;
        return o;
    endfunction

    out_t q0[$];
    out_t q1[$];
    out_t q2[$];
    out_t exp0, exp1, exp2;
    int   n_s = 0;
    int   n_d = 0;

    task automatic step(input bit rn, input bit e);
        @(negedge clk);
        rst_n = rn;
        en    = e;
        if (!rn) begin
            n_s  = 0;
            n_d  = 0;
            exp0 = reset_val(1'b0, 1'b0);
            exp1 = reset_val(1'b1, 1'b1);
            exp2 = reset_val(1'b0, 1'b0);
        end else if (e) begin
            exp0 = model_at(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, n_s);
            exp1 = model_at(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, n_s);
            exp2 = model_at(800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0, n_d);
            n_s++;
            n_d++;
        end else begin
            exp0.ls = 1'b0; exp0.fs = 1'b0;
            exp1.ls = 1'b0; exp1.fs = 1'b0;
            exp2.ls = 1'b0; exp2.fs = 1'b0;
        end
        q0.push_back(exp0);
        q1.push_back(exp1);
        q2.push_back(exp2);
    endtask

    task automatic check_out(input string nm, input out_t act, input out_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b vb=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b vb=%b",
                     nm, $time, act.hsync, act.vsync, act.de, act.pix_x, act.pix_y, act.ls, act.fs, act.vblank,
                     exp.hsync, exp.vsync, exp.de, exp.pix_x, exp.pix_y, exp.ls, exp.fs, exp.vblank);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Scoreboard monitor: every clock presents a new output word
    always @(posedge clk) begin
        #1;
        if (q0.size() != 0) check_out("small_pol0", act0, q0.pop_front());
        if (q1.size() != 0) check_out("small_pol1", act1, q1.pop_front());
        if (q2.size() != 0) check_out("default_mode", act2, q2.pop_front());
    end

    bit dir_on  = 1'b0;
    bit dir2_on = 1'b0;
    int cyc     = 0;
    int last_fs = -1;
    int last_ls = -1;
    int de_cnt  = 0;
    int vs_cnt  = 0;

    // Frame-level properties of the small mode and line-level ones of the default mode
    always @(posedge clk) begin
        #1;
        if (dir_on) begin
            cyc++;
            if (vif0.frame_start) begin
                if (last_fs >= 0) begin
                    chk("fs_period", cyc - last_fs, 48);
                    chk("de_per_frame", de_cnt, 12);
                    chk("vsync_low_per_frame", vs_cnt, 8);
                end
                last_fs = cyc;
                de_cnt  = 0;
                vs_cnt  = 0;
            end
            if (vif0.line_start) begin
                if (last_ls >= 0) chk("ls_period", cyc - last_ls, 8);
                last_ls = cyc;
            end
            de_cnt += int'(vif0.de);
            vs_cnt += int'(!vif0.vsync);
            if (!vif0.vsync) chk("vsync_row", int'(vif0.pix_y), 4);
            chk("hsync_window_small", int'(vif0.hsync == 1'b0),
                int'(vif0.pix_x == 11'd5 || vif0.pix_x == 11'd6));
        end
        if (dir2_on) begin
            chk("hsync_window_default", int'(vif2.hsync == 1'b0),
                int'(vif2.pix_x >= 11'd840 && vif2.pix_x <= 11'd967));
            if (vif2.pix_x == 11'd800) chk("de_low_at_800", int'(vif2.de), 0);
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step(1'b0, 1'b0);

        dir_on = 1'b1;
        repeat (110) step(1'b1, 1'b1);
        dir_on = 1'b0;

        for (int i = 0; i < 20; i++) step(1'b1, (i % 2) == 0);

        repeat (400) step($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1);

        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp0.pix_x == 11'd3 && exp0.pix_y == 11'd2 && rst_n) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b1);
        end
        chk("reach_3_2", int'(found), 1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        @(posedge clk);
        #2;
        chk("post_reset_fs", int'(vif0.frame_start), 1);
        chk("post_reset_x", int'(vif0.pix_x), 0);

        dir2_on = 1'b1;
        repeat (2200) step(1'b1, 1'b1);
        dir2_on = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
